max_value_requester: RTL and testbench

MAX_VALUE_REQUESTER -- requirements
Module: max_value_requester

---
 rtl/max_value_req_pkg.sv | 20 ++
 rtl/uart_bit_timer.sv | 29 ++
 rtl/max_value_requester.sv | 182 ++++++++++++++++++
 tb/tb_max_value_requester.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/max_value_req_pkg.sv
// rtl/max_value_req_pkg.sv - shared state encoding and opcode constants for max_value_requester
package max_value_req_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TX_START,
        TX_DATA,
        TX_STOP,
        RX_WAIT,
        RX_START,
        RX_DATA,
        RX_STOP
    } state_t;

    localparam logic [7:0] OP_MAX_CH1 = 8'h01;
    localparam logic [7:0] OP_MAX_CH2 = 8'h02;
    localparam logic [7:0] OP_MAX_CH3 = 8'h03;
    localparam logic [7:0] OP_MAX_CH4 = 8'h04;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - free-running bit-period counter with half- and full-period ticks
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic half_tick,
    output logic full_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear || (cnt == FULL_LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign half_tick = (cnt == HALF_LAST);
    assign full_tick = (cnt == FULL_LAST);

endmodule

// File: rtl/max_value_requester.sv
// rtl/max_value_requester.sv - half-duplex UART requester: sends an opcode, awaits one response byte
module max_value_requester
    import max_value_req_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 868,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [7:0] req_opcode,
    output logic       req_ready,
    output logic       tx_serial,
    input  logic       rx_serial,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_timeout,
    output logic       rsp_error,
    output logic       busy
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t state, state_next;

    logic [7:0]      tx_shift, tx_shift_next;
    logic [7:0]      rx_shift, rx_shift_next;
    logic [2:0]      bit_cnt, bit_cnt_next;
    logic [TO_W-1:0] to_cnt, to_cnt_next;
    logic            tx_next;
    logic [7:0]      data_next;
    logic            valid_next, timeout_next, error_next;

    logic rx_meta, rx_sync, rx_prev;
    logic rx_fall;
    logic half_tick, full_tick, timer_clear;

    // Timer restarts on every state change so each phase begins at a bit boundary
    // (TX) or at the detected start edge / start-bit midpoint (RX).
    assign timer_clear = (state_next != state) || (state == IDLE) || (state == RX_WAIT);

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (timer_clear),
        .half_tick (half_tick),
        .full_tick (full_tick)
    );

    assign rx_fall   = rx_prev && !rx_sync;
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            tx_serial   <= 1'b1;
            tx_shift    <= '0;
            rx_shift    <= '0;
            bit_cnt     <= '0;
            to_cnt      <= '0;
            rsp_data    <= 8'h00;
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_error   <= 1'b0;
            rx_meta     <= 1'b1;
            rx_sync     <= 1'b1;
            rx_prev     <= 1'b1;
        end else begin
            state       <= state_next;
            tx_serial   <= tx_next;
            tx_shift    <= tx_shift_next;
            rx_shift    <= rx_shift_next;
            bit_cnt     <= bit_cnt_next;
            to_cnt      <= to_cnt_next;
            rsp_data    <= data_next;
            rsp_valid   <= valid_next;
            rsp_timeout <= timeout_next;
            rsp_error   <= error_next;
            rx_meta     <= rx_serial;
            rx_sync     <= rx_meta;
            rx_prev     <= rx_sync;
        end
    end

    always_comb begin
        state_next    = state;
        tx_next       = tx_serial;
        tx_shift_next = tx_shift;
        rx_shift_next = rx_shift;
        bit_cnt_next  = bit_cnt;
        to_cnt_next   = to_cnt;
        data_next     = rsp_data;
        valid_next    = 1'b0;
        timeout_next  = 1'b0;
        error_next    = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next    = TX_START;
                    tx_shift_next = req_opcode;
                    tx_next       = 1'b0;
                    bit_cnt_next  = '0;
                end
            end
            TX_START: begin
                if (full_tick) begin
                    state_next    = TX_DATA;
                    tx_next       = tx_shift[0];
                    tx_shift_next = {1'b0, tx_shift[7:1]};
                end
            end
            TX_DATA: begin
                if (full_tick) begin
                    if (bit_cnt == 3'd7) begin
                        state_next   = TX_STOP;
                        tx_next      = 1'b1;
                        bit_cnt_next = '0;
                    end else begin
                        tx_next       = tx_shift[0];
                        tx_shift_next = {1'b0, tx_shift[7:1]};
                        bit_cnt_next  = bit_cnt + 3'd1;
                    end
                end
            end
            TX_STOP: begin
                if (full_tick) begin
                    state_next  = RX_WAIT;
                    to_cnt_next = '0;
                end
            end
            RX_WAIT: begin
                if (rx_fall) begin
                    state_next = RX_START;
                end else if (to_cnt == TO_LAST) begin
                    state_next   = IDLE;
                    timeout_next = 1'b1;
                end else begin
                    to_cnt_next = to_cnt + TO_W'(1);
                end
            end
            RX_START: begin
                // A high line at the midpoint means the edge was a glitch; the
                // timeout budget keeps running from where it stood.
                if (half_tick) begin
                    if (!rx_sync) begin
                        state_next   = RX_DATA;
                        bit_cnt_next = '0;
                    end else begin
                        state_next = RX_WAIT;
                    end
                end
            end
            RX_DATA: begin
                if (full_tick) begin
                    rx_shift_next = {rx_sync, rx_shift[7:1]};
                    if (bit_cnt == 3'd7) begin
                        state_next   = RX_STOP;
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (full_tick) begin
                    state_next = IDLE;
                    if (rx_sync) begin
                        data_next  = rx_shift;
                        valid_next = 1'b1;
                    end else begin
                        error_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_max_value_requester.sv
// tb/tb_max_value_requester.sv - randomized self-checking bench for max_value_requester
module tb_max_value_requester;
    import max_value_req_pkg::*;

    localparam int CPB = 4;
    localparam int TO  = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [7:0] req_opcode;
    logic       req_ready;
    logic       tx_serial;
    logic       rx_serial;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_timeout;
    logic       rsp_error;
    logic       busy;

    int checks_total  = 0;
    int checks_passed = 0;

    logic [7:0] exp_data;
    int obs_valid, obs_err, obs_to;
    logic obs_ready;

    max_value_requester #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_opcode  (req_opcode),
        .req_ready   (req_ready),
        .tx_serial   (tx_serial),
        .rx_serial   (rx_serial),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .rsp_error   (rsp_error),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line level of an 8N1 frame, cycle c counted from 1 after the accept cycle.
    function automatic logic tx_model(input logic [7:0] op, input int c);
        int pos;
        pos = (c - 1) / CPB;
        if (pos == 0) return 1'b0;
        if (pos >= 9) return 1'b1;
        return op[pos-1];
    endfunction

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_opcode = 8'h00; rx_serial = 1'b1;
        repeat (3) tick();
        checks_total++;
        if ({tx_serial, req_ready, busy, rsp_valid, rsp_timeout, rsp_error} !== 6'b110000)
            $display("FAIL reset_outputs got tx/rdy/busy/v/to/err=%b expected 110000",
                     {tx_serial, req_ready, busy, rsp_valid, rsp_timeout, rsp_error});
        else checks_passed++;
        checks_total++;
        if (rsp_data !== 8'h00) $display("FAIL reset_data got %h expected 00", rsp_data);
        else checks_passed++;
        reset = 1'b0;
        tick();
        exp_data = 8'h00;
    endtask

    // Sends op; optionally fires a second request while busy, which must be dropped.
    task automatic test_tx_frame(input logic [7:0] op, input logic busy_req);
        int inj;
        inj = $urandom_range(2, 38);
        checks_total++;
        if (req_ready !== 1'b1) $display("FAIL tx_ready_idle got %b expected 1", req_ready);
        else checks_passed++;
        req_valid = 1'b1; req_opcode = op;
        tick();
        req_valid = 1'b0; req_opcode = ~op;
        for (int c = 1; c <= 10 * CPB; c++) begin
            checks_total++;
            if (tx_serial !== tx_model(op, c) || busy !== 1'b1 || req_ready !== 1'b0)
                $display("FAIL tx_frame op=%h cycle=%0d got tx=%b busy=%b rdy=%b expected tx=%b busy=1 rdy=0",
                         op, c, tx_serial, busy, req_ready, tx_model(op, c));
            else checks_passed++;
            req_valid = busy_req && (c == inj);
            tick();
        end
        req_valid = 1'b0;
    endtask

    task automatic run_response(input logic [7:0] b, input logic stop);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        obs_valid = 0; obs_err = 0; obs_to = 0; obs_ready = 1'b0;
        for (int i = 0; i < 10 * CPB + 12; i++) begin
            rx_serial = (i < 10 * CPB) ? frame[i / CPB] : 1'b1;
            tick();
            if (rsp_valid) begin obs_valid++; obs_ready = req_ready; end
            if (rsp_error) obs_err++;
            if (rsp_timeout) obs_to++;
        end
    endtask

    task automatic test_response(input logic [7:0] b, input logic stop, input string name);
        repeat ($urandom_range(0, 10)) tick();
        run_response(b, stop);
        if (stop) exp_data = b;
        checks_total++;
        if (obs_valid != int'(stop) || obs_err != int'(!stop) || obs_to != 0)
            $display("FAIL %s_pulses got valid=%0d err=%0d to=%0d expected valid=%0d err=%0d to=0",
                     name, obs_valid, obs_err, obs_to, int'(stop), int'(!stop));
        else checks_passed++;
        checks_total++;
        if (rsp_data !== exp_data) $display("FAIL %s_data got %h expected %h", name, rsp_data, exp_data);
        else checks_passed++;
        if (stop) begin
            checks_total++;
            if (obs_ready !== 1'b1) $display("FAIL %s_ready got %b expected 1", name, obs_ready);
            else checks_passed++;
        end
    endtask

    // Called right after test_tx_frame, i.e. in the first RX_WAIT cycle.
    task automatic test_timeout();
        for (int k = 0; k <= TO + 5; k++) begin
            checks_total++;
            if (rsp_timeout !== (k == TO) || rsp_valid !== 1'b0 || rsp_error !== 1'b0)
                $display("FAIL timeout k=%0d got to=%b v=%b err=%b expected to=%b v=0 err=0",
                         k, rsp_timeout, rsp_valid, rsp_error, (k == TO));
            else checks_passed++;
            if (k == TO) begin
                checks_total++;
                if (req_ready !== 1'b1) $display("FAIL timeout_ready got %b expected 1", req_ready);
                else checks_passed++;
            end
            tick();
        end
    endtask

    task automatic test_glitch(input logic [7:0] b);
        repeat ($urandom_range(0, 5)) tick();
        rx_serial = 1'b0;
        repeat (2) tick();
        rx_serial = 1'b1;
        repeat (6) tick();
        test_response(b, 1'b1, "glitch");
    endtask

    task automatic test_random(input int n);
        logic [7:0] op, b;
        logic stop;
        for (int i = 0; i < n; i++) begin
            op = 8'($urandom);
            b = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            test_tx_frame(op, $urandom_range(0, 1) == 1);
            test_response(b, stop, "random");
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] op;
        int highs;
        op = 8'($urandom) & 8'h7F;
        req_valid = 1'b1; req_opcode = op;
        tick();
        req_valid = 1'b0;
        repeat (6) tick();
        req_valid = 1'b1; req_opcode = 8'hFF;
        tick();
        req_valid = 1'b0;
        repeat (5) tick();
        reset = 1'b1; req_valid = 1'b1;
        tick();
        checks_total++;
        if ({tx_serial, req_ready, busy, rsp_valid, rsp_timeout, rsp_error} !== 6'b110000 || rsp_data !== 8'h00)
            $display("FAIL midreset_outputs got tx/rdy/busy/v/to/err=%b data=%h expected 110000 data=00",
                     {tx_serial, req_ready, busy, rsp_valid, rsp_timeout, rsp_error}, rsp_data);
        else checks_passed++;
        req_valid = 1'b0;
        tick();
        reset = 1'b0;
        highs = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (tx_serial === 1'b1 && busy === 1'b0) highs++;
        end
        checks_total++;
        if (highs != 60) $display("FAIL midreset_quiet got %0d idle cycles expected 60", highs);
        else checks_passed++;
    endtask

    initial begin
        test_reset();
        test_tx_frame(OP_MAX_CH2, 1'b0);
        test_response(8'hA5, 1'b1, "resp_a5");
        test_tx_frame(8'($urandom), 1'b1);
        test_timeout();
        test_tx_frame(OP_MAX_CH3, 1'b1);
        test_response(8'h3C, 1'b0, "stop_err");
        test_tx_frame(OP_MAX_CH4, 1'b0);
        test_glitch(8'h7E);
        test_random(5);
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
